featuremap_frame_ctrl: RTL and testbench
========================================

// Module: featuremap_frame_ctrl
// PURPOSE
//  Frame sequencer for one conv2d5x5 feature-map engine. Accepts a start pulse, then gates one
//  IMG_W x IMG_H raster frame into the engine. Tracks row/col and masks engine outputs whose
//  KxK window is incomplete (warm-up rows/cols), so only valid windows are emitted.
//  After the pipeline drains it pulses done. Sits between the pixel source and the engine.
// PARAMETERS
//  DWIDTH    8   pixel / result width
//  IMG_W     32  frame width in pixels (>= K)
//  IMG_H     32  frame height in pixels (>= K)
//  K         5   kernel size
//  PIPE_LAT  3   engine latency, data_valid -> data_valid_out, fixed cycles (>= 1)
// PORTS
//  clock          in   1       system clock
//  reset          in   1       asynchronous, active-low reset
//  start          in   1       one-cycle frame start request
//  busy           out  1       high from start acceptance until done
//  done           out  1       one-cycle pulse, frame complete
//  in_data        in   DWIDTH  source pixel
//  in_valid       in   1       source pixel valid
//  in_ready       out  1       controller accepts pixel; accept = in_valid & in_ready
//  eng_data_in    out  DWIDTH  to engine data_in (in_data passed through)
//  eng_valid      out  1       to engine data_valid (= accept)
//  eng_data_out   in   DWIDTH  from engine data_out
//  eng_valid_out  in   1       from engine data_valid_out
//  out_data       out  DWIDTH  masked result
//  out_valid      out  1       result belongs to a complete KxK window
// BEHAVIOUR
//  - Reset: state IDLE, busy=0, done=0, in_ready=0, out_valid=0, counters and mask pipe cleared.
//    eng_data_in, eng_valid, out_data are combinational; eng_valid=0 and out_valid=0 in reset.
//  - FSM: IDLE -start-> RUN.
//    RUN -accept of pixel (IMG_H-1, IMG_W-1)-> DRAIN.
//    DRAIN (PIPE_LAT cycles) -> DONE.
//    DONE (1 cycle, done=1) -> IDLE.
//  - start is ignored outside IDLE. busy=1 in RUN/DRAIN/DONE. in_ready=1 only in RUN.
//  - Counters col 0..IMG_W-1 and row 0..IMG_H-1 advance only on accept; col wraps to 0 and
//    increments row. Both clear on entry to RUN.
//    Width of each counter = $clog2 of its max value + 1.
//  - Window flag w = accept & (row >= K-1) & (col >= K-1). It enters a PIPE_LAT-deep shift
//    register that shifts every cycle (idle gaps shift 0).
//  - out_valid = eng_valid_out & tap. out_data = eng_data_out. Accept at cycle T aligns with
//    engine output at T+PIPE_LAT. Per frame: (IMG_W-K+1)*(IMG_H-K+1) out_valid.
//  - Last pixel accepted at T: last out_valid at T+PIPE_LAT, done=1 at T+PIPE_LAT+1.
//  - in_valid gaps anywhere in RUN are legal. in_valid outside RUN is not accepted.
//  - Reset mid-frame: immediately returns to IDLE with the mask pipe cleared, so no stale out_valid.
// CONFIGURATION
//  FMAP_COORD_EN defined: extra outputs out_row, out_col ($clog2(IMG_H-K+1)/$clog2(IMG_W-K+1)
//   bits, min 1). They give the output-map coordinate of the current out_valid beat: raster from
//   (0,0), wrapping on out_col. They reset to 0 and clear on done.
//  Undefined: ports and their counters are absent. All other behaviour is identical.
// STRUCTURE
//  Package fmap_ctrl_pkg: state enum (S_IDLE,S_RUN,S_DRAIN,S_DONE) and a clog2-based counter
//   width helper.
//  Sub-module fmap_valid_pipe (PIPE_LAT-deep 1-bit shift register with async active-low clear).
//   Instantiate it once. FSM and counters stay in the top.
// TESTING
//  1 Default params, 1024-pixel ramp with in_valid=1 throughout -> 784 out_valid. The first one
//    is the output of accept #132 (r4,c4), 3 cycles after that accept. done 4 cycles after
//    accept #1023.
//  2 Same frame with a random 30% in_valid gap pattern -> same 784 results in same order.
//    done is PIPE_LAT+1 cycles after the last accept.
//  3 Pulse start in RUN and in DRAIN -> ignored; a single done; counters undisturbed.
//  4 Assert reset low at accept #500, release, restart -> no out_valid after reset. The next
//    frame yields exactly 784 outputs.
//  5 Engine model holds eng_valid_out=1 on warm-up outputs -> out_valid stays 0 for rows 0..3
//    and cols 0..3.
//  6 Build with FMAP_COORD_EN -> the first out_valid has coordinate (0,0). The 29th has (1,0).
//    The last has (27,27).

Source files
------------

// File: rtl/fmap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fmap_ctrl_pkg
// Shared types and helpers for the feature-map frame controller.
//   state_t  : frame sequencer states (idle, streaming, draining, done pulse)
//   cnt_w()  : width of a counter that must hold 0..maxval
//   coord_w(): width of an output-map coordinate counter for n positions (min 1)
// -----------------------------------------------------------------------------
package fmap_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int cnt_w(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval) + 1;
    endfunction

    function automatic int coord_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fmap_valid_pipe.sv
// -----------------------------------------------------------------------------
// fmap_valid_pipe
// DEPTH-deep 1-bit shift register carrying the "complete window" flag alongside
// the engine pipeline. Shifts every cycle; cleared asynchronously on reset so no
// stale flag survives a mid-frame reset.
// Ports:
//   clk_i   in  1  clock
//   rst_ni  in  1  asynchronous active-low clear
//   din_i   in  1  flag entering the pipe
//   dout_o  out 1  flag delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module fmap_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic dout_o
);

    logic [DEPTH-1:0] sr_q;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) sr_q <= '0;
                else         sr_q <= din_i;
            end
        end else begin : g_multi
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) sr_q <= '0;
                else         sr_q <= {sr_q[DEPTH-2:0], din_i};
            end
        end
    endgenerate

    assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/featuremap_frame_ctrl.sv
// -----------------------------------------------------------------------------
// featuremap_frame_ctrl
// Frame sequencer for one conv2d5x5 feature-map engine. After a start pulse it
// gates one IMG_W x IMG_H raster frame into the engine, tracks row/col of each
// accepted pixel and masks engine results whose KxK window is incomplete. Once
// the engine pipeline drains it pulses done for one cycle.
// Ports:
//   clock          in   1       system clock
//   reset          in   1       asynchronous active-low reset
//   start          in   1       frame start request (honoured only when idle)
//   busy           out  1       frame in progress (RUN/DRAIN/DONE)
//   done           out  1       one-cycle frame-complete pulse
//   in_data        in   DWIDTH  source pixel
//   in_valid       in   1       source pixel valid
//   in_ready       out  1       pixel accepted when in_valid & in_ready
//   eng_data_in    out  DWIDTH  pixel to engine
//   eng_valid      out  1       pixel valid to engine (= accept)
//   eng_data_out   in   DWIDTH  engine result
//   eng_valid_out  in   1       engine result valid
//   out_data       out  DWIDTH  result
//   out_valid      out  1       result from a complete KxK window
//   out_row/out_col (only with FMAP_COORD_EN) output-map coordinate of the beat
// Configuration macro: FMAP_COORD_EN adds out_row/out_col and their counters.
// -----------------------------------------------------------------------------
module featuremap_frame_ctrl
    import fmap_ctrl_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int K        = 5,
    parameter int PIPE_LAT = 3,
    localparam int ORW     = coord_w(IMG_H - K + 1),
    localparam int OCW     = coord_w(IMG_W - K + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] eng_data_in,
    output logic              eng_valid,
    input  logic [DWIDTH-1:0] eng_data_out,
    input  logic              eng_valid_out,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid
`ifdef FMAP_COORD_EN
    ,
    output logic [ORW-1:0]    out_row,
    output logic [OCW-1:0]    out_col
`endif
);

    localparam int RW = cnt_w(IMG_H - 1);
    localparam int CW = cnt_w(IMG_W - 1);
    localparam int DW = cnt_w(PIPE_LAT - 1);

    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [DW-1:0] DRN_LAST  = DW'(PIPE_LAT - 1);

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [DW-1:0] drain_q, drain_d;

    logic accept;
    logic win;
    logic tap;

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign in_ready    = (state_q == S_RUN);
    assign accept      = in_valid & in_ready;
    assign eng_valid   = accept;
    assign eng_data_in = in_data;

    // A result is kept only if its window's bottom-right pixel lies at or beyond
    // row K-1 / col K-1; the flag rides beside the engine for PIPE_LAT cycles.
    assign win = accept & (row_q >= ROW_FIRST) & (col_q >= COL_FIRST);

    fmap_valid_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_valid_pipe (
        .clk_i  (clock),
        .rst_ni (reset),
        .din_i  (win),
        .dout_o (tap)
    );

    assign out_valid = eng_valid_out & tap;
    assign out_data  = eng_data_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            drain_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            // Hold off done until the last pixel's result has left the engine.
            S_DRAIN: begin
                if (drain_q == DRN_LAST) state_d = S_DONE;
                else                     drain_d = drain_q + 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef FMAP_COORD_EN
    localparam logic [OCW-1:0] OCOL_LAST = OCW'(IMG_W - K);

    logic [ORW-1:0] orow_q, orow_d;
    logic [OCW-1:0] ocol_q, ocol_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            orow_q <= '0;
            ocol_q <= '0;
        end else begin
            orow_q <= orow_d;
            ocol_q <= ocol_d;
        end
    end

    // Coordinates describe the current beat and advance after it.
    always_comb begin
        orow_d = orow_q;
        ocol_d = ocol_q;
        if (done) begin
            orow_d = '0;
            ocol_d = '0;
        end else if (out_valid) begin
            if (ocol_q == OCOL_LAST) begin
                ocol_d = '0;
                orow_d = orow_q + 1'b1;
            end else begin
                ocol_d = ocol_q + 1'b1;
            end
        end
    end

    assign out_row = orow_q;
    assign out_col = ocol_q;
`endif

endmodule

// File: tb/tb_featuremap_frame_ctrl.sv
module tb_featuremap_frame_ctrl;

    localparam int DW  = 8;
    localparam int PL  = 3;
    localparam int NPX = 1024;
    localparam int NOUT = 784;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] eng_data_in;
    logic          eng_valid;
    logic [DW-1:0] eng_data_out;
    logic          eng_valid_out;
    logic [DW-1:0] out_data;
    logic          out_valid;
`ifdef FMAP_COORD_EN
    logic [4:0]    out_row;
    logic [4:0]    out_col;
`endif

    featuremap_frame_ctrl dut (
        .clock         (clock),
        .reset         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .eng_data_in   (eng_data_in),
        .eng_valid     (eng_valid),
        .eng_data_out  (eng_data_out),
        .eng_valid_out (eng_valid_out),
        .out_data      (out_data),
        .out_valid     (out_valid)
`ifdef FMAP_COORD_EN
        ,
        .out_row       (out_row),
        .out_col       (out_col)
`endif
    );

    always #5 clock = ~clock;

    // Identity engine: fixed PL-cycle delay of data and valid.
    logic [PL-1:0] dly_v = '0;
    logic [DW-1:0] dly_d [PL];
    logic          force_eng;

    always @(posedge clock) begin
        dly_v    <= {dly_v[PL-2:0], eng_valid};
        dly_d[0] <= eng_data_in;
        for (int k = 1; k < PL; k++) dly_d[k] <= dly_d[k-1];
    end

    assign eng_valid_out = force_eng ? 1'b1 : dly_v[PL-1];
    assign eng_data_out  = dly_d[PL-1];

    // Monitor (sampled on the falling edge).
    int cyc = 0;
    int fidx = 0, aidx = 0;
    int out_cnt = 0, ord_err = 0, done_cnt = 0, frame_outs = 0;
    int acc132 = 0, lastacc = 0, first_out = 0, done_cyc = 0;
    int co0r = -1, co0c = -1, co28r = -1, co28c = -1, colr = -1, colc = -1;

    function automatic logic [7:0] exp_pix(input int idx);
        int r, c;
        r = 4 + idx / 28;
        c = 4 + idx % 28;
        return 8'((r * 32 + c) & 255);
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (out_valid) out_cnt <= out_cnt + 1;
        if (!rst_n) begin
            fidx <= 0;
            aidx <= 0;
        end else begin
            if (eng_valid) begin
                if (aidx == 132)  acc132  <= cyc;
                if (aidx == 1023) lastacc <= cyc;
            end
            if (out_valid) begin
                if (fidx >= NOUT || out_data !== exp_pix(fidx)) ord_err <= ord_err + 1;
                if (fidx == 0) first_out <= cyc;
`ifdef FMAP_COORD_EN
                if (fidx == 0)        begin co0r  <= int'(out_row); co0c  <= int'(out_col); end
                if (fidx == 28)       begin co28r <= int'(out_row); co28c <= int'(out_col); end
                if (fidx == NOUT - 1) begin colr  <= int'(out_row); colc  <= int'(out_col); end
`endif
            end
            if (done) begin
                frame_outs <= fidx;
                done_cyc   <= cyc;
                done_cnt   <= done_cnt + 1;
                fidx       <= 0;
                aidx       <= 0;
            end else begin
                if (out_valid) fidx <= fidx + 1;
                if (eng_valid) aidx <= aidx + 1;
            end
        end
    end

    int checks = 0, passes = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse start, then stream pixels until 'limit' are accepted.
    task automatic send_frame(input int gap, input int limit, input int start_at);
        int i, guard;
        bit took;
        start = 1'b1;
        tick();
        start = 1'b0;
        i = 0;
        guard = 0;
        while (i < limit && guard < 20000) begin
            in_valid = (gap == 0) || ($urandom_range(99) >= gap);
            in_data  = 8'(i);
            start    = (i == start_at);
            took     = in_valid && in_ready;
            tick();
            if (took) i++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("accepts", i, limit);
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk("done_seen", done_cnt - d0, 1);
    endtask

    task automatic check_frame();
        chk("outs_per_frame", frame_outs, NOUT);
        chk("order_errors", ord_err, 0);
        chk("first_out_lat", first_out - acc132, PL);
        chk("done_lat", done_cyc - lastacc, PL + 1);
        chk("idle_after", int'(busy), 0);
    endtask

    initial begin
        int d0, base;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = '0; force_eng = 1'b1;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_eng_valid", int'(eng_valid), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        in_valid = 1'b0; force_eng = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        in_valid = 1'b1;
        tick();
        chk("idle_no_accept", int'(eng_valid), 0);
        in_valid = 1'b0;

        // 1: continuous ramp
        d0 = done_cnt;
        send_frame(0, NPX, -1);
        wait_done(d0);
        check_frame();

        // 2: 30% gaps
        d0 = done_cnt;
        send_frame(30, NPX, -1);
        wait_done(d0);
        check_frame();

        // 3: start during RUN and during DRAIN
        d0 = done_cnt;
        send_frame(0, NPX, 300);
        chk("in_drain_busy", int'(busy), 1);
        chk("in_drain_ready", int'(in_ready), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(d0);
        repeat (10) tick();
        chk("single_done", done_cnt - d0, 1);
        check_frame();

        // 4: reset mid-frame
        send_frame(0, 500, -1);
        base = out_cnt;
        rst_n = 1'b0;
        repeat (2) tick();
        chk("midrst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (10) tick();
        chk("no_out_after_rst", out_cnt - base, 0);
        d0 = done_cnt;
        send_frame(0, NPX, -1);
        wait_done(d0);
        check_frame();

        // 5: engine claims valid everywhere
        force_eng = 1'b1;
        d0 = done_cnt;
        send_frame(0, NPX, -1);
        wait_done(d0);
        force_eng = 1'b0;
        check_frame();

`ifdef FMAP_COORD_EN
        chk("coord_first_r", co0r, 0);
        chk("coord_first_c", co0c, 0);
        chk("coord_29th_r", co28r, 1);
        chk("coord_29th_c", co28c, 0);
        chk("coord_last_r", colr, 27);
        chk("coord_last_c", colc, 27);
        chk("coord_clr_r", int'(out_row), 0);
        chk("coord_clr_c", int'(out_col), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
